// File: rtl/adder_pkg.sv
// Shared definitions for the segmented adder / accumulator.
//   state_t    : control FSM encoding (IDLE, RUN, DONE)
//   calc_nseg  : number of SEG-bit segments in a WIDTH-bit word
//   seg_idx_w  : width of the segment index register, clog2(NSEG), at least 1
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned calc_nseg(input int unsigned width,
                                            input int unsigned seg);
    return width / seg;
  endfunction

  // A single segment still needs a 1-bit index register so the datapath
  // keeps the same shape for SEG == WIDTH.
  function automatic int unsigned seg_idx_w(input int unsigned nseg);
    return (nseg > 1) ? int'($clog2(nseg)) : 1;
  endfunction

endpackage

// File: rtl/adder_seg_acc_if.sv
// Request/response bundle of the segmented adder / accumulator.
//   Request  : in_valid, in_ready, a, b, cin, mode, clear
//   Response : out_valid, out_ready, sum, cout, carry_cnt
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result is consumed on a rising edge where out_valid && out_ready. Once
// out_valid is high, sum/cout stay stable until that consuming edge. in_valid
// is not required to be held, and is ignored while in_ready is low (nothing
// is queued). clear is a side-band strobe sampled only while in_ready is high.
interface adder_seg_acc_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             mode;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [CNT_W-1:0] carry_cnt;

  modport master (
    output in_valid, a, b, cin, mode, clear, out_ready,
    input  in_ready, out_valid, sum, cout, carry_cnt
  );

  modport slave (
    input  in_valid, a, b, cin, mode, clear, out_ready,
    output in_ready, out_valid, sum, cout, carry_cnt
  );
endinterface

// File: rtl/adder_seg_slice.sv
// Combinational SEG-bit adder slice with carry in and carry out.
//   a, b : SEG-bit operand segments
//   ci   : carry into the segment
//   s    : SEG-bit sum segment
//   co   : carry out of the segment
module adder_seg_slice #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);

  // One extra bit on each operand captures the carry out.
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};

endmodule

// File: rtl/adder_seg_acc.sv
// Segmented adder / accumulator. Adds SEG bits per cycle, LSB segment first,
// through a single shared slice, so a WIDTH-bit add takes WIDTH/SEG cycles.
//   clk, rstn : clock and asynchronous active-low reset
//   bus       : request/response bundle (slave side)
//               mode=0 : sum = a + b + cin
//               mode=1 : sum = acc + a + cin; acc <= sum when the result is
//                        consumed, carry_cnt counts results with cout=1
//                        (saturating)
//               clear  : zeroes acc and carry_cnt, only while idle
//   state_dbg : current FSM state
module adder_seg_acc
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  adder_seg_acc_if.slave       bus,
  output state_t               state_dbg
);

  localparam int unsigned NSEG   = calc_nseg(WIDTH, SEG);
  localparam int unsigned IDX_W  = seg_idx_w(NSEG);
  localparam int unsigned BASE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  generate
    if ((WIDTH % SEG) != 0) begin : g_bad_seg
      $error("adder_seg_acc: WIDTH must be a multiple of SEG");
    end
  endgenerate

  state_t             state;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   work;       // partial result being built during RUN
  logic [WIDTH-1:0]   work_next;
  logic [WIDTH-1:0]   sum_r;      // last completed result
  logic [WIDTH-1:0]   acc;
  logic               carry;
  logic               cout_r;
  logic               mode_r;
  logic               out_valid_r;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   carry_cnt_r;

  logic [BASE_W-1:0]  seg_base;
  logic [SEG-1:0]     seg_a;
  logic [SEG-1:0]     seg_b;
  logic [SEG-1:0]     seg_s;
  logic               seg_co;
  logic               last_seg;

  // Segment select/insert via indexed part-selects on a shared base.
  always_comb begin
    seg_base  = BASE_W'(idx * SEG);
    seg_a     = op_a[seg_base +: SEG];
    seg_b     = op_b[seg_base +: SEG];
    work_next = work;
    work_next[seg_base +: SEG] = seg_s;
  end

  assign last_seg = (idx == IDX_W'(NSEG - 1));

  adder_seg_slice #(.SEG(SEG)) u_slice (
    .a  (seg_a),
    .b  (seg_b),
    .ci (carry),
    .s  (seg_s),
    .co (seg_co)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      work        <= '0;
      sum_r       <= '0;
      acc         <= '0;
      carry       <= 1'b0;
      cout_r      <= 1'b0;
      mode_r      <= 1'b0;
      out_valid_r <= 1'b0;
      idx         <= '0;
      carry_cnt_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clear) begin
            acc         <= '0;
            carry_cnt_r <= '0;
          end
          if (bus.in_valid) begin
            op_a   <= bus.a;
            // A simultaneous clear takes effect first, so accumulate sees 0.
            op_b   <= bus.mode ? (bus.clear ? '0 : acc) : bus.b;
            carry  <= bus.cin;
            mode_r <= bus.mode;
            idx    <= '0;
            work   <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          carry <= seg_co;
          work  <= work_next;
          if (last_seg) begin
            // Visible result only changes once the whole word is done.
            sum_r       <= work_next;
            cout_r      <= seg_co;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
            if (mode_r) begin
              acc <= sum_r;
              if (cout_r && (carry_cnt_r != '1)) begin
                carry_cnt_r <= carry_cnt_r + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.carry_cnt = carry_cnt_r;
  assign state_dbg     = state;

endmodule

// File: tb/tb_adder_seg_acc.sv
// Directed bench for adder_seg_acc (WIDTH=32, SEG=8, CNT_W=8).
module tb_adder_seg_acc;
  import adder_pkg::*;

  logic   clk;
  logic   rstn;
  state_t state_dbg;
  int     tests;
  int     fails;

  adder_seg_acc_if #(.WIDTH(32), .CNT_W(8)) bus ();

  adder_seg_acc #(.WIDTH(32), .SEG(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Drivers: every task starts and ends 1 time unit after a rising edge.
  task automatic start_op(input logic m, input logic [31:0] av, input logic [31:0] bv,
                          input logic ci, input logic clr);
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.a        = av;
    bus.b        = bv;
    bus.cin      = ci;
    bus.clear    = clr;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_seen", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input logic m, input logic [31:0] av, input logic [31:0] bv,
                        input logic ci, input logic clr,
                        output logic [31:0] s, output logic co, output int lat);
    start_op(m, av, bv, ci, clr);
    wait_valid(lat);
    s  = bus.sum;
    co = bus.cout;
    take_result();
  endtask

  logic [31:0] s;
  logic        co;
  int          lat;

  initial begin
    tests = 0;
    fails = 0;
    rstn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.mode      = 1'b0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", bus.sum, 32'h0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_carry_cnt", 32'(bus.carry_cnt), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Full carry ripple, latency NSEG=4
    run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, s, co, lat);
    check("ripple_sum", s, 32'h0000_0000);
    check("ripple_cout", 32'(co), 32'd1);
    check("ripple_latency", 32'(lat), 32'd4);
    check("ripple_cnt", 32'(bus.carry_cnt), 32'd0);

    // Plain add with cin
    run_op(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, s, co, lat);
    check("add_sum", s, 32'h2345_678A);
    check("add_cout", 32'(co), 32'd0);
    check("hold_after_take_sum", bus.sum, 32'h2345_678A);
    check("hold_after_take_valid", 32'(bus.out_valid), 32'd0);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Clear, then three accumulates of 0x80000000
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    run_op(1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, s, co, lat);
    check("acc1_sum", s, 32'h8000_0000);
    check("acc1_cout", 32'(co), 32'd0);
    run_op(1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, s, co, lat);
    check("acc2_sum", s, 32'h0000_0000);
    check("acc2_cout", 32'(co), 32'd1);
    run_op(1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, s, co, lat);
    check("acc3_sum", s, 32'h8000_0000);
    check("acc3_cout", 32'(co), 32'd0);
    check("acc3_cnt", 32'(bus.carry_cnt), 32'd1);

    // Clear together with an accumulate request: acc treated as 0
    run_op(1'b1, 32'h0000_0001, 32'h0, 1'b0, 1'b1, s, co, lat);
    check("clr_acc_sum", s, 32'h0000_0001);
    check("clr_acc_cnt", 32'(bus.carry_cnt), 32'd0);

    // mode=0 leaves acc alone (acc=1)
    run_op(1'b0, 32'h0000_0005, 32'h0000_0006, 1'b0, 1'b0, s, co, lat);
    check("m0_sum", s, 32'h0000_000B);
    run_op(1'b1, 32'h0000_0002, 32'h0000_0000, 1'b0, 1'b0, s, co, lat);
    check("acc_after_m0_sum", s, 32'h0000_0003);

    // Saturating carry counter: acc + 0xFFFFFFFF + 1 always carries
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    for (int i = 0; i < 255; i++) begin
      run_op(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, s, co, lat);
    end
    check("sat_255_cnt", 32'(bus.carry_cnt), 32'd255);
    run_op(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, s, co, lat);
    check("sat_256_sum", s, 32'h0000_0000);
    check("sat_256_cout", 32'(co), 32'd1);
    check("sat_256_cnt", 32'(bus.carry_cnt), 32'd255);

    // Back-pressure in DONE: result held, requests ignored
    start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.mode     = 1'b1;
      bus.a        = 32'h0000_0077;
      @(posedge clk); #1;
      check("stall_sum", bus.sum, 32'hFFFF_FFFF);
      check("stall_cout", 32'(bus.cout), 32'd1);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    take_result();
    check("stall_release_in_ready", 32'(bus.in_ready), 32'd1);
    check("stall_release_cnt", 32'(bus.carry_cnt), 32'd255);
    @(posedge clk); #1;
    check("stall_no_queued_op", 32'(state_dbg), 32'(IDLE));

    // Reset during RUN segment 2 of an accumulate
    run_op(1'b1, 32'h0000_0100, 32'h0, 1'b0, 1'b0, s, co, lat);
    check("pre_rst_sum", s, 32'h0000_0100);
    start_op(1'b1, 32'h0000_0007, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("mid_run_state", 32'(state_dbg), 32'(RUN));
    rstn = 1'b0;
    #1;
    check("async_rst_sum", bus.sum, 32'h0);
    check("async_rst_cout", 32'(bus.cout), 32'd0);
    check("async_rst_cnt", 32'(bus.carry_cnt), 32'd0);
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    run_op(1'b1, 32'h0000_0005, 32'h0, 1'b0, 1'b0, s, co, lat);
    check("post_rst_acc_zero", s, 32'h0000_0005);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adder_seg_acc.md
ADDER_SEG_ACC -- requirements
Module: adder_seg_acc

Interface
- REQ-001: Parameter WIDTH, default 32: operand and result width in bits.
- REQ-002: Parameter SEG, default 8: bits added per cycle; WIDTH % SEG == 0 is required, otherwise elaboration SHALL fail.
- REQ-003: Parameter CNT_W, default 8: carry-counter width in bits.
- REQ-004: clk  in  1  single clock; all state updates on the rising edge.
- REQ-005: rstn  in  1  reset, asynchronous, active-low.
- REQ-006: in_valid  in  1  operand request.
- REQ-007: in_ready  out  1  block can accept a request.
- REQ-008: a  in  WIDTH  first operand.
- REQ-009: b  in  WIDTH  second operand; ignored when mode=1.
- REQ-010: cin  in  1  carry into the LSB segment.
- REQ-011: mode  in  1  0 = sum a+b+cin; 1 = accumulate, acc+a+cin.
- REQ-012: clear  in  1  synchronous clear of acc and carry_cnt.
- REQ-013: out_valid  out  1  result available.
- REQ-014: out_ready  in  1  consumer takes the result.
- REQ-015: sum  out  WIDTH  result.
- REQ-016: cout  out  1  carry out of the MSB segment.
- REQ-017: carry_cnt  out  CNT_W  saturating count of accumulate operations that produced cout=1.

Function
- REQ-018: The FSM SHALL have three states: IDLE, RUN and DONE.
- REQ-019: in_ready SHALL be 1 exactly when the FSM is in IDLE.
- REQ-020: A transfer on in_valid&in_ready SHALL:
  - latch a, b (or acc when mode=1), cin and mode;
  - clear the segment index;
  - move the FSM to RUN.
- REQ-021: In RUN, each cycle SHALL add operand segment k (LSB first, SEG bits) plus the carry register, write sum segment k and update the carry register; cin seeds the carry.
- REQ-022: After segment NSEG-1 (NSEG = WIDTH/SEG), the FSM SHALL enter DONE.
  - cout = final carry.
  - out_valid rises NSEG cycles after the accept edge.
- REQ-023: In DONE, out_valid SHALL be 1 and sum/cout SHALL be held stable until out_valid&out_ready; the FSM then returns to IDLE.
- REQ-024: On the DONE→IDLE edge with latched mode=1:
  - acc SHALL be loaded with sum.
  - If cout=1, carry_cnt SHALL increment, saturating at all-ones.
- REQ-025: With mode=0, acc and carry_cnt SHALL be unaffected.
- REQ-026: While out_valid=0, sum and cout SHALL keep their last completed values; they are not zero-masked.
- REQ-027: clear SHALL act only in IDLE and SHALL be ignored in RUN and DONE.
- REQ-028: If clear and an accepted mode=1 request occur in the same cycle, clear SHALL win first, so the operation uses acc=0.
- REQ-029: If SEG == WIDTH, latency SHALL be 1 cycle (NSEG=1); the same rules apply.
- REQ-030: in_valid SHALL be ignored outside IDLE; no input queueing.

Reset
- REQ-031: rstn low SHALL asynchronously set:
  - FSM = IDLE;
  - acc, sum, cout, carry_cnt, segment index and carry register = 0;
  - out_valid = 0.
- REQ-032: Asserting reset mid-RUN or mid-DONE SHALL abort the operation with no acc update.
- REQ-033: in_ready SHALL be 1 from the first edge after rstn deasserts.

Structure
- REQ-034: Shared package adder_pkg SHALL hold:
  - the state enum (IDLE/RUN/DONE);
  - the NSEG computation;
  - the segment-index width function clog2(NSEG).
- REQ-035: One sub-module, adder_seg_slice, SHALL implement the combinational SEG-bit add with carry-in and carry-out, instantiated once.
- REQ-036: Segment select and insert SHALL use indexed part-selects, with no per-segment replication.

Verification (WIDTH=32, SEG=8, CNT_W=8)
- REQ-037: mode=0, a=0xFFFFFFFF, b=0x00000001, cin=0 → sum=0x00000000, cout=1; out_valid rises 4 cycles after accept; carry_cnt stays 0.
- REQ-038: mode=0, a=0x12345678, b=0x11111111, cin=1 → sum=0x2345678A, cout=0.
- REQ-039: clear, then three mode=1 operations with a=0x80000000, cin=0 → sums 0x80000000, 0x00000000 (cout=1), 0x80000000; carry_cnt=1.
- REQ-040: Preload carry_cnt=255 via 255 carrying accumulates, then one more carrying accumulate → carry_cnt stays 255.
- REQ-041: Hold out_ready=0 for 5 cycles in DONE → sum/cout stable, in_ready=0, in_valid pulses ignored; one out_ready cycle → IDLE.
- REQ-042: Pulse rstn low during RUN segment 2 of a mode=1 operation → all outputs 0 asynchronously, acc=0, in_ready=1 after release.
